id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Instruction-decode operand stage of the RV32I pipeline. It sits between the IF/ID register and the EX stage. It drives the register-file read indices, resolves RAW hazards by bypassing from EX and writeback, and inserts a one-cycle bubble on load-use hazards. Results are registered into the ID/EX pipeline register.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word presented on out_instr while in reset or in a bubble (addi x0,x0,0)
- CNT_W, 32, width of the saturating load-use stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_instr  in  32  instruction word from IF/ID
- in_pc  in  32  PC of in_instr
- in_ready  out  1  stage accepts in_instr this cycle; 0 = upstream must hold
- ra1  out  5  register-file read index 1 = in_instr[19:15]
- ra2  out  5  register-file read index 2 = in_instr[24:20]
- rd1  in  32  register-file read data 1, combinational from ra1
- rd2  in  32  register-file read data 2, combinational from ra2
- ex_wen  in  1  instruction in EX writes a register
- ex_wa  in  5  EX destination index
- ex_wd  in  32  EX ALU result
- ex_is_load  in  1  EX instruction is a load; ex_wd not valid
- wb_wen  in  1  writeback enable, same signal as register-file write_en
- wb_wa  in  5  writeback index
- wb_wd  in  32  writeback data
- flush  in  1  kill the instruction in ID (branch/jump redirect)
- out_valid  out  1  ID/EX holds a valid instruction
- out_pc  out  32  registered PC
- out_instr  out  32  registered instruction
- out_rs1_val  out  32  resolved rs1 operand
- out_rs2_val  out  32  resolved rs2 operand
- out_rd  out  5  destination index; 0 when the instruction writes no register
- stall_cnt  out  CNT_W  number of load-use bubbles inserted, saturating at all-ones

## Operation
- Decode uses opcode = in_instr[6:0].
  - uses_rs1 = 0 for LUI 0110111, AUIPC 0010111, and JAL 1101111; 1 for all other opcodes.
  - uses_rs2 = 1 only for R 0110011, S 0100011, and B 1100011.
  - out_rd = in_instr[11:7] except for S and B opcodes, where it is 0.
- Operand resolution, per source s with index rs, in strict priority order:
  - rs==0 -> 0.
  - ex_wen & !ex_is_load & ex_wa==rs -> ex_wd.
  - wb_wen & wb_wa==rs -> wb_wd.
  - otherwise rd1/rd2.
- The WB bypass is mandatory: the register file updates only at the edge.
- Load-use hazard: hz = in_valid & ex_wen & ex_is_load & ex_wa!=0 & ((uses_rs1 & ex_wa==rs1) | (uses_rs2 & ex_wa==rs2)).
- Load data appears on wb_* exactly one cycle after ex_is_load is asserted.
- Next-state selection at each edge, in priority order:
  - flush -> bubble, in_ready=1, counter unchanged.
  - hz -> bubble, in_ready=0, stall_cnt+1 unless already saturated.
  - else -> load all outputs from the decode/resolution logic, with out_valid=in_valid, in_ready=1.
- Bubble: out_valid=0, out_instr=NOP_INSTR, out_rd=0, and out_rs1_val/out_rs2_val/out_pc=0.
- When in_valid=0, the stage captures a bubble and hz is forced to 0.

## Timing
- ra1/ra2 and in_ready are combinational from inputs in the same cycle. There are no registered paths into them.
- Latency is 1 cycle: values resolved in cycle n appear on out_* after edge n.
- A load-use hazard costs exactly one bubble. The held instruction re-evaluates the next cycle and picks up the load result via the wb bypass.
- Flush and hazard in the same cycle: flush wins, the instruction is dropped, and there is no stall or count.
- rst (asynchronous, at any time, including mid-stall) forces:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR;
  - out_rs1_val=0, out_rs2_val=0, out_rd=0;
  - stall_cnt=0.
- in_ready is combinational, so it reads 1 while rst is high and hz=0.

## Test plan
- Reset mid-stall (stall_cnt=3) -> all outputs at reset values, out_instr=32'h0000_0013, stall_cnt=0.
- Register file x5=0; in the same cycle, wb writes x5=32'hDEADBEEF and ID holds add x6,x5,x5 -> out_rs1_val=out_rs2_val=32'hDEADBEEF, out_rd=6.
- ex_wa=5/ex_wd=32'h11 and wb_wa=5/wb_wd=32'h22, ID holds sub x1,x5,x5 -> both operands 32'h11 (EX priority).
- EX holds load to x7, ID holds add x8,x7,x0:
  - cycle 1: in_ready=0, bubble, stall_cnt=1;
  - cycle 2: wb_wa=7, wb_wd=32'h55 -> out_rs1_val=32'h55, out_rs2_val=0, out_valid=1.
- x0 and decode: ex_wen=1, ex_wa=0, ex_wd=32'h99 with rs1=x0 -> operand 0. LUI whose rs1 field equals the load destination -> no stall. sw x3,0(x4) -> out_rd=0.
- Flush during a load-use hazard -> out_valid=0, in_ready=1, stall_cnt unchanged. stall_cnt at all-ones plus another hazard -> stays all-ones.

Source files
------------

// File: rtl/id_operand_if.sv
// ID operand stage bus: IF/ID input, register-file read port, EX/WB bypass
// sources and the registered ID/EX output. The slave side is the stage itself.
interface id_operand_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic [31:0]      rd1;
  logic [31:0]      rd2;
  logic             ex_wen;
  logic [4:0]       ex_wa;
  logic [31:0]      ex_wd;
  logic             ex_is_load;
  logic             wb_wen;
  logic [4:0]       wb_wa;
  logic [31:0]      wb_wd;
  logic             flush;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [31:0]      out_rs1_val;
  logic [31:0]      out_rs2_val;
  logic [4:0]       out_rd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, in_pc, rd1, rd2,
           ex_wen, ex_wa, ex_wd, ex_is_load, wb_wen, wb_wa, wb_wd, flush,
    input  in_ready, ra1, ra2, out_valid, out_pc, out_instr,
           out_rs1_val, out_rs2_val, out_rd, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rd1, rd2,
           ex_wen, ex_wa, ex_wd, ex_is_load, wb_wen, wb_wa, wb_wd, flush,
    output in_ready, ra1, ra2, out_valid, out_pc, out_instr,
           out_rs1_val, out_rs2_val, out_rd, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// RV32I decode operand stage: register-file read, EX/WB bypass, load-use bubble
// insertion, and the ID/EX pipeline register.

// One source operand: bypass priority and the load-use match for that source.
module id_operand_bypass (
  input  logic [4:0]  rs,
  input  logic        used,
  input  logic [31:0] rf_data,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_wa,
  input  logic [31:0] ex_wd,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  output logic [31:0] val,
  output logic        load_hit
);
  // WB must bypass: the register file only commits at the edge.
  always_comb begin
    if (rs == 5'd0)                                val = '0;
    else if (ex_wen && !ex_is_load && ex_wa == rs) val = ex_wd;
    else if (wb_wen && wb_wa == rs)                val = wb_wd;
    else                                           val = rf_data;
  end

  assign load_hit = used && ex_wen && ex_is_load && (ex_wa != 5'd0) && (ex_wa == rs);
endmodule

module id_operand_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_operand_if.slave  bus
);
  localparam int NUM_SRC = 2;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } id_ex_t;

  typedef enum logic [1:0] {
    SEL_LOAD,
    SEL_BUBBLE,
    SEL_STALL
  } sel_e;

  localparam id_ex_t BUBBLE = '{
    valid:   1'b0,
    pc:      32'h0,
    instr:   NOP_INSTR,
    rs1_val: 32'h0,
    rs2_val: 32'h0,
    rd:      5'd0
  };

  logic [6:0]                opcode;
  logic                      writes_rd;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_SRC-1:0]        load_hit;
  logic [NUM_SRC-1:0][4:0]   rs_idx;
  logic [NUM_SRC-1:0][31:0]  rf_val;
  logic [NUM_SRC-1:0][31:0]  src_val;
  logic                      hz;
  sel_e                      sel;
  id_ex_t                    id_ex_d, id_ex_q;
  logic [CNT_W-1:0]          cnt_q;

  assign opcode = bus.in_instr[6:0];
  assign rs_idx = {bus.in_instr[24:20], bus.in_instr[19:15]};
  assign rf_val = {bus.rd2, bus.rd1};

  always_comb begin
    src_used[0] = 1'b1;
    src_used[1] = 1'b0;
    writes_rd   = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: src_used[0] = 1'b0;
      OP_R:                     src_used[1] = 1'b1;
      OP_S, OP_B: begin
        src_used[1] = 1'b1;
        writes_rd   = 1'b0;
      end
      default: ;
    endcase
  end

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      id_operand_bypass u_byp (
        .rs         (rs_idx[s]),
        .used       (src_used[s]),
        .rf_data    (rf_val[s]),
        .ex_wen     (bus.ex_wen),
        .ex_is_load (bus.ex_is_load),
        .ex_wa      (bus.ex_wa),
        .ex_wd      (bus.ex_wd),
        .wb_wen     (bus.wb_wen),
        .wb_wa      (bus.wb_wa),
        .wb_wd      (bus.wb_wd),
        .val        (src_val[s]),
        .load_hit   (load_hit[s])
      );
    end
  endgenerate

  assign hz           = bus.in_valid && (|load_hit);
  assign bus.ra1      = rs_idx[0];
  assign bus.ra2      = rs_idx[1];
  // A flush drops the stalled instruction, so upstream may advance.
  assign bus.in_ready = bus.flush || !hz;

  always_comb begin
    sel = SEL_LOAD;
    if (bus.flush || !bus.in_valid) sel = SEL_BUBBLE;
    else if (hz)                    sel = SEL_STALL;
  end

  always_comb begin
    id_ex_d = BUBBLE;
    if (sel == SEL_LOAD) begin
      id_ex_d.valid   = 1'b1;
      id_ex_d.pc      = bus.in_pc;
      id_ex_d.instr   = bus.in_instr;
      id_ex_d.rs1_val = src_val[0];
      id_ex_d.rs2_val = src_val[1];
      id_ex_d.rd      = writes_rd ? bus.in_instr[11:7] : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= BUBBLE;
    else     id_ex_q <= id_ex_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cnt_q <= '0;
    else if (sel == SEL_STALL && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.out_valid   = id_ex_q.valid;
  assign bus.out_pc      = id_ex_q.pc;
  assign bus.out_instr   = id_ex_q.instr;
  assign bus.out_rs1_val = id_ex_q.rs1_val;
  assign bus.out_rs2_val = id_ex_q.rs2_val;
  assign bus.out_rd      = id_ex_q.rd;
  assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vectors, a spec-level reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_id_operand_stage;
  localparam int          CW  = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_operand_if #(.CNT_W(CW)) bus ();

  id_operand_stage #(.NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment register file: combinational read, write at the edge, x0 fixed.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (bus.wb_wen && bus.wb_wa != 5'd0) rf[bus.wb_wa] <= bus.wb_wd;
  assign bus.rd1 = rf[bus.ra1];
  assign bus.rd2 = rf[bus.ra2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  int          m_cnt;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction
  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
  endfunction
  function automatic bit has_rd(input logic [6:0] op);
    return !(op == 7'b0100011 || op == 7'b1100011);
  endfunction
  function automatic logic [31:0] value_of(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (bus.ex_wen && !bus.ex_is_load && bus.ex_wa == r) return bus.ex_wd;
    if (bus.wb_wen && bus.wb_wa == r) return bus.wb_wd;
    return rf[r];
  endfunction

  initial begin : cmp
    logic [6:0] op;
    logic [4:0] s1, s2;
    bit         hz;
    forever begin
      @(negedge clk); #4;
      op = bus.in_instr[6:0];
      s1 = bus.in_instr[19:15];
      s2 = bus.in_instr[24:20];
      hz = bus.in_valid && bus.ex_wen && bus.ex_is_load && bus.ex_wa != 0 &&
           ((reads_rs1(op) && bus.ex_wa == s1) || (reads_rs2(op) && bus.ex_wa == s2));
      check("m_ra1", {27'd0, bus.ra1}, {27'd0, s1});
      check("m_ra2", {27'd0, bus.ra2}, {27'd0, s2});
      check("m_in_ready", {31'd0, bus.in_ready}, {31'd0, bus.flush || !hz});
      if (rst || bus.flush || !bus.in_valid || hz) begin
        m_valid = 0; m_pc = 0; m_instr = NOP; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        if (rst) m_cnt = 0;
        else if (!bus.flush && hz && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m_valid = 1; m_pc = bus.in_pc; m_instr = bus.in_instr;
        m_rs1 = value_of(s1); m_rs2 = value_of(s2);
        m_rd = has_rd(op) ? bus.in_instr[11:7] : 5'd0;
      end
      @(posedge clk); #1;
      check("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("m_out_pc", bus.out_pc, m_pc);
      check("m_out_instr", bus.out_instr, m_instr);
      check("m_out_rs1_val", bus.out_rs1_val, m_rs1);
      check("m_out_rs2_val", bus.out_rs2_val, m_rs2);
      check("m_out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
      check("m_stall_cnt", {29'd0, bus.stall_cnt}, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    bus.in_valid = 0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.ex_wen = 0; bus.ex_wa = 0; bus.ex_wd = 0; bus.ex_is_load = 0;
    bus.wb_wen = 0; bus.wb_wa = 0; bus.wb_wd = 0; bus.flush = 0;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1; bus.in_instr = instr; bus.in_pc = pc;
  endtask

  task automatic ex_load(input logic [4:0] wa);
    bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_wa = wa; bus.ex_wd = 32'hBAD0_BAD0;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  initial begin : drv
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0000_0013);
    check("rst_stall_cnt", {29'd0, bus.stall_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 0;

    // WB bypass: x5 written this cycle, still 0 in the register file
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd5, 5'd5, 5'd6), 32'h0000_0100);
    bus.wb_wen = 1; bus.wb_wa = 5; bus.wb_wd = 32'hDEAD_BEEF;
    edge_settle();
    check("wb_rs1", bus.out_rs1_val, 32'hDEAD_BEEF);
    check("wb_rs2", bus.out_rs2_val, 32'hDEAD_BEEF);
    check("wb_rd", {27'd0, bus.out_rd}, 32'd6);
    check("wb_pc", bus.out_pc, 32'h0000_0100);

    // EX has priority over WB
    @(negedge clk); idle();
    present(enc_r(7'b0100000, 5'd5, 5'd5, 5'd1), 32'h0000_0104);
    bus.ex_wen = 1; bus.ex_wa = 5; bus.ex_wd = 32'h11;
    bus.wb_wen = 1; bus.wb_wa = 5; bus.wb_wd = 32'h22;
    edge_settle();
    check("expri_rs1", bus.out_rs1_val, 32'h11);
    check("expri_rs2", bus.out_rs2_val, 32'h11);

    // Load-use: one bubble, then WB bypass of the load result
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd0, 5'd7, 5'd8), 32'h0000_0108);
    ex_load(5'd7);
    #1 check("lu_in_ready", {31'd0, bus.in_ready}, 32'd0);
    edge_settle();
    check("lu_bubble_valid", {31'd0, bus.out_valid}, 32'd0);
    check("lu_bubble_instr", bus.out_instr, NOP);
    check("lu_cnt1", {29'd0, bus.stall_cnt}, 32'd1);
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd0, 5'd7, 5'd8), 32'h0000_0108);
    bus.wb_wen = 1; bus.wb_wa = 7; bus.wb_wd = 32'h55;
    #1 check("lu_held_ready", {31'd0, bus.in_ready}, 32'd1);
    edge_settle();
    check("lu_rs1", bus.out_rs1_val, 32'h55);
    check("lu_rs2", bus.out_rs2_val, 32'h0);
    check("lu_valid", {31'd0, bus.out_valid}, 32'd1);

    // x0 is never bypassed
    @(negedge clk); idle();
    present(enc_addi(12'd5, 5'd0, 5'd9), 32'h0000_010C);
    bus.ex_wen = 1; bus.ex_wa = 0; bus.ex_wd = 32'h99;
    edge_settle();
    check("x0_rs1", bus.out_rs1_val, 32'h0);

    // LUI ignores its rs1 field: no stall
    @(negedge clk); idle();
    present(enc_lui(20'h00038, 5'd10), 32'h0000_0110);
    ex_load(5'd7);
    #1 check("lui_ready", {31'd0, bus.in_ready}, 32'd1);
    edge_settle();
    check("lui_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lui_cnt", {29'd0, bus.stall_cnt}, 32'd1);

    // Store writes no register
    @(negedge clk); idle();
    present(enc_sw(5'd3, 5'd4), 32'h0000_0114);
    edge_settle();
    check("sw_rd", {27'd0, bus.out_rd}, 32'd0);
    check("sw_valid", {31'd0, bus.out_valid}, 32'd1);

    // Flush beats a load-use hazard
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd0, 5'd7, 5'd8), 32'h0000_0118);
    ex_load(5'd7); bus.flush = 1;
    #1 check("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    edge_settle();
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_cnt", {29'd0, bus.stall_cnt}, 32'd1);

    // Two more stalls (rs2 hazard on an R-type), then reset mid-stall
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle();
      present(enc_r(7'd0, 5'd12, 5'd1, 5'd2), 32'h0000_011C);
      ex_load(5'd12);
      edge_settle();
    end
    check("pre_rst_cnt", {29'd0, bus.stall_cnt}, 32'd3);
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd12, 5'd1, 5'd2), 32'h0000_011C);
    ex_load(5'd12);
    #2 rst = 1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_instr", bus.out_instr, 32'h0000_0013);
    check("arst_pc", bus.out_pc, 32'h0);
    check("arst_rs1", bus.out_rs1_val, 32'h0);
    check("arst_rs2", bus.out_rs2_val, 32'h0);
    check("arst_rd", {27'd0, bus.out_rd}, 32'd0);
    check("arst_cnt", {29'd0, bus.stall_cnt}, 32'd0);
    edge_settle();
    @(negedge clk); rst = 0; idle();

    // Saturation: CNT_MAX stalls fill the counter, one more leaves it there
    for (int i = 0; i < CNT_MAX; i++) begin
      @(negedge clk); idle();
      present(enc_r(7'd0, 5'd0, 5'd13, 5'd14), 32'h0000_0120);
      ex_load(5'd13);
      edge_settle();
    end
    check("sat_full", {29'd0, bus.stall_cnt}, 32'd7);
    @(negedge clk); idle();
    present(enc_r(7'd0, 5'd0, 5'd13, 5'd14), 32'h0000_0120);
    ex_load(5'd13);
    edge_settle();
    check("sat_hold", {29'd0, bus.stall_cnt}, 32'd7);

    // Invalid input with a matching load: bubble, no stall
    @(negedge clk); idle();
    bus.in_instr = enc_r(7'd0, 5'd0, 5'd13, 5'd14);
    ex_load(5'd13);
    #1 check("inv_ready", {31'd0, bus.in_ready}, 32'd1);
    edge_settle();
    check("inv_valid", {31'd0, bus.out_valid}, 32'd0);

    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
